// File: rtl/a7link_rsp_rx.sv
// a7link_rsp_rx: deframes the serial return stream into 40-bit responses, with request timeout and frame stats
module a7link_rsp_rx #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serin,
  input  logic            req_start,
  output logic [39:0]     rsp_word,
  output logic            rsp_valid,
  output logic            busy,
  output logic            timeout,
  output logic [CNTW-1:0] bytes_seen,
  output logic [CNTW-1:0] frame_errs
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [39:0] part_q, part_d, word_q, word_d, pnext;
  logic valid_q, valid_d, busy_q, busy_d, tmo_q, tmo_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CNTW-1:0] bytes_q, bytes_d, errs_q, errs_d;
  logic [10:0] frame;
  logic last, good, bad, done, expire;
  // frame = {c, d7..d0, stop1, stop2}; the current serin is the second stop bit when last is set
  always_comb begin
    frame   = {sh_q, serin};
    last    = state_q == RECV && cnt_q == 4'd10;
    good    = last && frame[1:0] == 2'b00;
    bad     = last && frame[1:0] != 2'b00;
    pnext   = {part_q[31:0], frame[9:2]};
    done    = good && frame[10];
    expire  = busy_q && !done && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    state_d = state_q == IDLE ? (serin ? RECV : IDLE) : (last ? IDLE : RECV);
    cnt_d   = state_q == RECV ? cnt_q + 4'd1 : 4'd0;
    sh_d    = state_q == RECV ? frame[9:0] : sh_q;
    part_d  = (bad || done || expire) ? 40'd0 : good ? pnext : part_q;
    word_d  = done ? pnext : req_start ? 40'd0 : word_q;
    valid_d = done;
    busy_d  = req_start || (busy_q && !done && !expire);
    tmo_d   = expire;
    tcnt_d  = req_start ? '0 : busy_q ? tcnt_q + TW'(1) : tcnt_q;
    bytes_d = bytes_q + CNTW'(good);
    errs_d  = errs_q + CNTW'(bad);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      part_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      tcnt_q  <= '0;
      bytes_q <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      part_q  <= part_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
      bytes_q <= bytes_d;
      errs_q  <= errs_d;
    end
  end
  assign rsp_word   = word_q;
  assign rsp_valid  = valid_q;
  assign busy       = busy_q;
  assign timeout    = tmo_q;
  assign bytes_seen = bytes_q;
  assign frame_errs = errs_q;
endmodule

// File: tb/tb_a7link_rsp_rx.sv
// tb_a7link_rsp_rx: scoreboard bench for the response deframer
module tb_a7link_rsp_rx;
  localparam int TO = 80;
  logic clk = 1'b0, reset = 1'b1, serin = 1'b0, req_start = 1'b0;
  logic [39:0] rsp_word;
  logic rsp_valid, busy, timeout;
  logic [15:0] bytes_seen, frame_errs;
  a7link_rsp_rx #(.TIMEOUT_CYCLES(TO), .CNTW(16)) u_dut (
    .clk(clk), .reset(reset), .serin(serin), .req_start(req_start),
    .rsp_word(rsp_word), .rsp_valid(rsp_valid), .busy(busy), .timeout(timeout),
    .bytes_seen(bytes_seen), .frame_errs(frame_errs)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [39:0] w; int c; logic b;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [39:0] mp = '0;
  int mb = 0, me = 0, nb, nt;
  logic [11:0] f;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (rsp_valid === 1'b1) begin
    exp_t e;
    if (q.size() == 0) check("unexp_rsp", 1, 0);
    else begin
      e = q.pop_front();
      check("rsp_word", rsp_word, e.w);
      check("rsp_cycle", cyc, e.c);
      check("rsp_busy", busy, e.b);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mp = '0; mb = 0; me = 0;
  endtask
  task automatic idle(input int n);
    serin = 1'b0;
    repeat (n) tick();
  endtask
  task automatic req();
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask
  task automatic send(input bit c, input bit [7:0] d, input bit bad, input bit eb, input int req_at);
    logic [11:0] fr;
    int s;
    fr = {1'b1, c, d, 1'b0, bad};
    s = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      serin = fr[11-i];
      req_start = (i == req_at);
      tick();
    end
    serin = 1'b0;
    req_start = 1'b0;
    if (bad) begin
      me++;
      mp = '0;
    end else begin
      mb++;
      mp = {mp[31:0], d};
      if (c) begin
        q.push_back('{w: mp, c: s + 11, b: eb});
        mp = '0;
      end
    end
  endtask
  task automatic window();
    nb = 0; nt = 0;
    for (int i = 0; i < TO + 5; i++) begin
      @(negedge clk);
      nb += int'(busy);
      nt += int'(timeout);
    end
    tick();
  endtask
  initial begin
    tick(); tick();
    do_reset();
    check("rst_word", rsp_word, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout, 0);
    check("rst_bytes", bytes_seen, 0);
    check("rst_errs", frame_errs, 0);
    idle(2);
    req();
    check("busy_armed", busy, 1);
    send(0, 8'h12, 0, 0, -1); idle(1);
    send(0, 8'h34, 0, 0, -1); idle(1);
    send(0, 8'h56, 0, 0, -1); idle(1);
    send(0, 8'h78, 0, 0, -1); idle(1);
    send(1, 8'h9A, 0, 0, -1); idle(2);
    check("t1_bytes", bytes_seen, mb);
    check("t1_busy", busy, 0);
    req();
    check("req_clr", rsp_word, 0);
    window();
    mp = '0;
    check("t2_busy_len", nb, TO);
    check("t2_tmo_pulses", nt, 1);
    check("t2_word", rsp_word, 0);
    check("t2_busy", busy, 0);
    do_reset(); idle(2);
    send(0, 8'h55, 1, 0, -1); idle(1);
    send(1, 8'h01, 0, 0, -1); idle(2);
    check("t3_errs", frame_errs, me);
    check("t3_bytes", bytes_seen, mb);
    for (int k = 1; k <= 7; k++) send(k == 7, 8'(k), 0, 0, -1);
    idle(2);
    check("t4_bytes", bytes_seen, mb);
    req();
    send(0, 8'h11, 0, 1, -1); idle(1);
    send(1, 8'h22, 0, 1, 11);
    window();
    mp = '0;
    check("t6_busy_len", nb, TO);
    check("t6_tmo_pulses", nt, 1);
    check("t6_word", rsp_word, 40'h0000001122);
    do_reset(); idle(2);
    f = {1'b1, 1'b0, 8'hA4, 2'b00};
    for (int i = 0; i < 12; i++) begin
      serin = f[11-i];
      reset = (i == 5);
      tick();
    end
    reset = 1'b0;
    mp = '0; mb = 1; me = 0;
    idle(14);
    check("t5_word", rsp_word, 0);
    send(0, 8'hAB, 0, 0, -1);
    send(1, 8'hCD, 0, 0, -1); idle(2);
    check("t5_bytes", bytes_seen, mb);
    check("t5_errs", frame_errs, me);
    idle(5);
    check("pending", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
